adder_pipe_param: RTL and testbench
===================================

// Module: adder_pipe_param
// PURPOSE
//   Parametrised, pipelined carry-chained adder/subtractor with a valid/ready handshake.
//   - Splits the WIDTH-bit operation into NSEG = WIDTH/SEG_W segments.
//   - Each segment adds in its own pipeline stage, and its carry is registered into the next stage.
//   - Serves multi-cycle datapath units (e.g. the multiplier accumulate and address units) where a
//     full-width ripple chain cannot close timing.
//   - Adds subtract mode and status flags.
// PARAMETERS
//   WIDTH  32  operand/result width in bits; must be a multiple of SEG_W (elaboration $error otherwise)
//   SEG_W   8  bits added per pipeline stage; NSEG = WIDTH/SEG_W stages, NSEG >= 1
// PORTS
//   i_clk        in   1      clock; all state changes on its rising edge
//   i_reset      in   1      synchronous, active-high reset
//   i_valid      in   1      operands/mode valid this cycle
//   o_ready      out  1      block can accept operands this cycle
//   i_a          in   WIDTH  operand A
//   i_b          in   WIDTH  operand B
//   i_cin        in   1      carry-in (add mode only)
//   i_sub        in   1      1: A - B (B inverted, carry-in forced 1, i_cin ignored); 0: A + B + i_cin
//   o_valid      out  1      result valid
//   i_ready      in   1      downstream accepts result this cycle
//   o_sum        out  WIDTH  result, modulo 2^WIDTH
//   o_cout       out  1      carry out of MSB (in sub mode: 1 = no borrow, i.e. A >= B unsigned)
//   o_overflow   out  1      signed overflow: (a_msb == b'_msb) && (sum_msb != a_msb), with b' = B or ~B
//   o_zero       out  1      o_sum == 0
// BEHAVIOUR
//   - Reset:
//     - Synchronous, active-high; clears every stage valid bit.
//     - o_valid = 0, o_sum = 0, o_cout = 0, o_overflow = 0, o_zero = 0.
//     - o_ready = 1 in the cycle after reset deasserts.
//     - Reset mid-operation discards all in-flight operations; no result is ever emitted for them.
//   - Pipeline:
//     - Stage s (0..NSEG-1) adds segment s with the registered carry from stage s-1.
//     - Stage 0 uses i_cin, or 1 when i_sub = 1.
//     - Higher, not-yet-added operand segments and the already-computed lower sum segments travel
//       skewed through each stage's registers.
//     - Segment s spans bits [s*SEG_W +: SEG_W].
//   - Stall and acceptance:
//     - adv = !o_valid || i_ready; o_ready = adv (combinational).
//     - When adv = 1, all stages shift together; when adv = 0, all stages hold, including bubbles.
//     - A transfer is accepted on an edge where i_valid && o_ready.
//   - Latency:
//     - With no stall, an operation accepted at edge k appears with o_valid = 1 after edge k+NSEG.
//     - Throughput is one operation per cycle.
//     - Bubbles propagate: stage valid = previous stage valid at adv.
//   - Output holding: outputs are registered and stay stable while o_valid && !i_ready.
//   - Flags:
//     - o_overflow and o_zero are computed in the last stage from the full registered result.
//     - They are valid only with o_valid; they are held at their last value when o_valid = 0.
//   - Boundaries:
//     - Carry out of bit WIDTH-1 goes to o_cout only; there is no wrap into bit 0.
//     - NSEG = 1 degenerates to a single registered adder with latency 1.
//     - Simultaneous i_valid, i_ready and a full pipeline accepts and emits in the same edge; no loss.
//     - i_valid = 0 while adv = 1 inserts a bubble.
// TESTING
//   - Reset: i_reset = 1 for 2 cycles with i_valid = 1 -> o_valid = 0, o_sum = 0 throughout;
//     o_ready = 1 after release.
//   - Carry chain: A = 0x0000_00FF, B = 0x0000_0001, add -> o_sum = 0x0000_0100, o_cout = 0,
//     o_valid exactly 4 cycles after accept.
//   - Full ripple: A = 0xFFFF_FFFF, B = 0, cin = 1 -> o_sum = 0, o_cout = 1, o_zero = 1;
//     then A = 0x7FFF_FFFF, B = 1 -> o_sum = 0x8000_0000, o_overflow = 1.
//   - Subtract: A = 5, B = 7, i_sub = 1, i_cin = 1 -> o_sum = 0xFFFF_FFFE, o_cout = 0,
//     o_overflow = 0; A = 0x8000_0000, B = 1 -> o_sum = 0x7FFF_FFFF, o_overflow = 1.
//   - Back-pressure: stream 8 back-to-back ops, drop i_ready for 3 cycles mid-stream -> o_ready = 0
//     during the stall, o_sum held, all 8 results emitted in order, no duplicate or lost result.
//   - Random: 10k random A/B/cin/sub with random i_valid/i_ready at WIDTH=32/SEG_W=8 and
//     WIDTH=16/SEG_W=16 -> every result matches the reference model {cout,sum} = A + (sub ? ~B : B) + c.

Source files
------------

// File: rtl/adder_pipe_param_if.sv
// Operand/result handshake bundle for adder_pipe_param.
// slave = the adder itself, master = whatever feeds operands and drains results.
interface adder_pipe_param_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
  logic             i_sub;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;
  logic             o_overflow;
  logic             o_zero;

  modport slave (
    input  i_valid, i_a, i_b, i_cin, i_sub, i_ready,
    output o_ready, o_valid, o_sum, o_cout, o_overflow, o_zero
  );

  modport master (
    output i_valid, i_a, i_b, i_cin, i_sub, i_ready,
    input  o_ready, o_valid, o_sum, o_cout, o_overflow, o_zero
  );
endinterface

// File: rtl/adder_pipe_param.sv
// Pipelined segmented adder/subtractor: one SEG_W-bit slice per stage, carry registered
// between stages, plus a registered output stage that also forms the overflow/zero flags.
module adder_pipe_param #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  adder_pipe_param_if.slave        bus,
  output logic [WIDTH/SEG_W-1:0]   dbg_stage_valid
);
  localparam int NSEG = WIDTH / SEG_W;

  if (SEG_W < 1 || NSEG < 1 || (WIDTH % SEG_W) != 0) begin : g_bad_params
    $error("adder_pipe_param: WIDTH (%0d) must be a positive multiple of SEG_W (%0d)", WIDTH, SEG_W);
  end

  // Handshake: an operand transfers on an edge with i_valid && o_ready; a result transfers on an
  // edge with o_valid && i_ready. The whole pipe advances together whenever the output register
  // is empty or being drained, so o_ready is simply that advance condition.
  logic adv;
  logic o_valid_q;
  logic [WIDTH-1:0] o_sum_q;
  logic o_cout_q, o_overflow_q, o_zero_q;

  assign adv         = !o_valid_q || bus.i_ready;
  assign bus.o_ready = adv;

  logic [NSEG-1:0]  st_v, in_v;
  logic [NSEG-1:0]  st_c, in_c, nx_c;
  logic [WIDTH-1:0] st_a   [NSEG];
  logic [WIDTH-1:0] st_b   [NSEG];
  logic [WIDTH-1:0] st_sum [NSEG];
  logic [WIDTH-1:0] in_a   [NSEG];
  logic [WIDTH-1:0] in_b   [NSEG];
  logic [WIDTH-1:0] in_sum [NSEG];
  logic [WIDTH-1:0] nx_sum [NSEG];

  for (genvar s = 0; s < NSEG; s++) begin : g_stage
    logic [SEG_W:0]   seg;
    logic [WIDTH-1:0] merged;

    if (s == 0) begin : g_head
      // B is stored already inverted in subtract mode, so later stages and the
      // overflow flag see B' directly.
      assign in_v[s]   = bus.i_valid;
      assign in_a[s]   = bus.i_a;
      assign in_b[s]   = bus.i_sub ? ~bus.i_b : bus.i_b;
      assign in_c[s]   = bus.i_sub | bus.i_cin;
      assign in_sum[s] = '0;
    end else begin : g_tail
      assign in_v[s]   = st_v[s-1];
      assign in_a[s]   = st_a[s-1];
      assign in_b[s]   = st_b[s-1];
      assign in_c[s]   = st_c[s-1];
      assign in_sum[s] = st_sum[s-1];
    end

    assign seg = {1'b0, in_a[s][s*SEG_W +: SEG_W]}
               + {1'b0, in_b[s][s*SEG_W +: SEG_W]}
               + {{SEG_W{1'b0}}, in_c[s]};

    always_comb begin
      merged                     = in_sum[s];
      merged[s*SEG_W +: SEG_W]   = seg[SEG_W-1:0];
    end

    assign nx_c[s]   = seg[SEG_W];
    assign nx_sum[s] = merged;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      st_v <= '0;
    end else if (adv) begin
      st_v <= in_v;
    end
  end

  // Datapath registers need no reset: nothing downstream looks at them without a valid bit.
  always_ff @(posedge i_clk) begin
    if (adv) begin
      for (int s = 0; s < NSEG; s++) begin
        st_a[s]   <= in_a[s];
        st_b[s]   <= in_b[s];
        st_sum[s] <= nx_sum[s];
      end
      st_c <= nx_c;
    end
  end

  // Output stage: flags are formed from the fully assembled sum and held while no result is valid.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid_q    <= 1'b0;
      o_sum_q      <= '0;
      o_cout_q     <= 1'b0;
      o_overflow_q <= 1'b0;
      o_zero_q     <= 1'b0;
    end else if (adv) begin
      o_valid_q <= st_v[NSEG-1];
      if (st_v[NSEG-1]) begin
        o_sum_q      <= st_sum[NSEG-1];
        o_cout_q     <= st_c[NSEG-1];
        o_overflow_q <= (st_a[NSEG-1][WIDTH-1] == st_b[NSEG-1][WIDTH-1]) &&
                        (st_sum[NSEG-1][WIDTH-1] != st_a[NSEG-1][WIDTH-1]);
        o_zero_q     <= (st_sum[NSEG-1] == '0);
      end
    end
  end

  assign bus.o_valid    = o_valid_q;
  assign bus.o_sum      = o_sum_q;
  assign bus.o_cout     = o_cout_q;
  assign bus.o_overflow = o_overflow_q;
  assign bus.o_zero     = o_zero_q;
  assign dbg_stage_valid = st_v;
endmodule

// File: tb/tb_adder_pipe_param.sv
// Bench for adder_pipe_param: a 32/8 instance for directed and random traffic, and a 16/16
// (single-stage) instance for random traffic, both scored against an arithmetic model.
module tb_adder_pipe_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] dbg_a;
  logic [0:0] dbg_b;

  int n_cmp = 0;
  int n_err = 0;
  int n_in_a = 0, n_out_a = 0, n_in_b = 0, n_out_b = 0;

  logic [34:0] exp_q_a[$];
  logic [34:0] exp_q_b[$];

  adder_pipe_param_if #(.WIDTH(32)) ifa();
  adder_pipe_param_if #(.WIDTH(16)) ifb();

  adder_pipe_param #(.WIDTH(32), .SEG_W(8)) dut_a (
    .i_clk(clk), .i_reset(rst), .bus(ifa.slave), .dbg_stage_valid(dbg_a)
  );
  adder_pipe_param #(.WIDTH(16), .SEG_W(16)) dut_b (
    .i_clk(clk), .i_reset(rst), .bus(ifb.slave), .dbg_stage_valid(dbg_b)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {zero, overflow, cout, sum} from plain integer arithmetic at width w.
  function automatic logic [34:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    longint unsigned aa, bb, tot, mask;
    longint sa, sb, sr, half;
    logic c, cout, ovf;
    logic [31:0] sum;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'h0, a} & mask;
    bb   = sub ? (~{32'h0, b} & mask) : ({32'h0, b} & mask);
    c    = sub ? 1'b1 : cin;
    tot  = aa + bb + {63'h0, c};
    sum  = tot[31:0] & mask[31:0];
    cout = tot[w];
    half = longint'(64'd1 << (w - 1));
    sa   = (aa >= 64'(half)) ? longint'(aa) - 2 * half : longint'(aa);
    sb   = (bb >= 64'(half)) ? longint'(bb) - 2 * half : longint'(bb);
    sr   = sa + sb + longint'({63'h0, c});
    ovf  = (sr >= half) || (sr < -half);
    return {sum == 32'h0, ovf, cout, sum};
  endfunction

  // ---------------- scoreboards ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q_a.delete();
    end else begin
      if (ifa.o_valid && ifa.i_ready) begin
        if (exp_q_a.size() == 0) check("a_spurious_result", {29'h0, ifa.o_sum, ifa.o_cout, ifa.o_overflow, ifa.o_zero}, 64'h0 - 1);
        else begin
          check("a_result", {29'h0, ifa.o_zero, ifa.o_overflow, ifa.o_cout, ifa.o_sum}, {29'h0, exp_q_a.pop_front()});
          n_out_a++;
        end
      end
      if (ifa.i_valid && ifa.o_ready) begin
        exp_q_a.push_back(model(32, ifa.i_a, ifa.i_b, ifa.i_cin, ifa.i_sub));
        n_in_a++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_q_b.delete();
    end else begin
      if (ifb.o_valid && ifb.i_ready) begin
        if (exp_q_b.size() == 0) check("b_spurious_result", {45'h0, ifb.o_sum, ifb.o_cout, ifb.o_overflow, ifb.o_zero}, 64'h0 - 1);
        else begin
          check("b_result", {29'h0, ifb.o_zero, ifb.o_overflow, ifb.o_cout, 16'h0, ifb.o_sum}, {29'h0, exp_q_b.pop_front()});
          n_out_b++;
        end
      end
      if (ifb.i_valid && ifb.o_ready) begin
        exp_q_b.push_back(model(16, {16'h0, ifb.i_a}, {16'h0, ifb.i_b}, ifb.i_cin, ifb.i_sub));
        n_in_b++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One operation on instance A with i_ready held high; reports the result and accept-to-valid latency.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub,
                        output logic [31:0] sum, output logic cout, output logic ovf,
                        output logic zero, output int lat);
    logic acc;
    acc = 1'b0;
    lat = -1;
    sum = '0; cout = 1'b0; ovf = 1'b0; zero = 1'b0;
    ifa.i_a = a; ifa.i_b = b; ifa.i_cin = cin; ifa.i_sub = sub; ifa.i_valid = 1'b1;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      acc = ifa.o_ready;
      step();
    end
    ifa.i_valid = 1'b0;
    check("op_accepted", {63'h0, acc}, 64'h1);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ifa.o_valid) begin
        lat = n - 1;
        sum = ifa.o_sum; cout = ifa.o_cout; ovf = ifa.o_overflow; zero = ifa.o_zero;
        break;
      end
    end
    step();
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] r_sum;
  logic r_cout, r_ovf, r_zero;
  int lat;
  logic [31:0] bp_a[8], bp_b[8];
  logic bp_c[8], bp_s[8];
  logic [34:0] hold_exp;
  int sent, base_out, start_a, start_b, cyc;

  initial begin
    ifa.i_valid = 1'b1; ifa.i_a = 32'h1234_5678; ifa.i_b = 32'h1; ifa.i_cin = 1'b0; ifa.i_sub = 1'b0; ifa.i_ready = 1'b1;
    ifb.i_valid = 1'b1; ifb.i_a = 16'h00ff;      ifb.i_b = 16'h1; ifb.i_cin = 1'b0; ifb.i_sub = 1'b0; ifb.i_ready = 1'b1;

    // Reset held 2 cycles with operands offered.
    rst = 1'b1;
    for (int n = 0; n < 2; n++) begin
      step();
      @(negedge clk);
      check("rst_a_valid", {63'h0, ifa.o_valid}, 64'h0);
      check("rst_a_sum", {32'h0, ifa.o_sum}, 64'h0);
      check("rst_a_flags", {61'h0, ifa.o_cout, ifa.o_overflow, ifa.o_zero}, 64'h0);
      check("rst_a_stages", {60'h0, dbg_a}, 64'h0);
      check("rst_b_valid", {63'h0, ifb.o_valid}, 64'h0);
    end
    step();
    rst = 1'b0;
    ifa.i_valid = 1'b0;
    ifb.i_valid = 1'b0;
    @(negedge clk);
    check("rst_release_ready_a", {63'h0, ifa.o_ready}, 64'h1);
    check("rst_release_ready_b", {63'h0, ifb.o_ready}, 64'h1);
    step();

    // Carry across a segment boundary, and latency.
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, r_sum, r_cout, r_ovf, r_zero, lat);
    check("carry_sum", {32'h0, r_sum}, 64'h100);
    check("carry_cout", {63'h0, r_cout}, 64'h0);
    check("carry_latency", 64'(lat), 64'd4);

    // Full ripple through every segment out of the MSB.
    run_op(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, r_sum, r_cout, r_ovf, r_zero, lat);
    check("ripple_sum", {32'h0, r_sum}, 64'h0);
    check("ripple_cout", {63'h0, r_cout}, 64'h1);
    check("ripple_zero", {63'h0, r_zero}, 64'h1);

    run_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, r_sum, r_cout, r_ovf, r_zero, lat);
    check("posovf_sum", {32'h0, r_sum}, 64'h8000_0000);
    check("posovf_ovf", {63'h0, r_ovf}, 64'h1);
    check("posovf_zero", {63'h0, r_zero}, 64'h0);

    // Subtract, i_cin ignored.
    run_op(32'd5, 32'd7, 1'b1, 1'b1, r_sum, r_cout, r_ovf, r_zero, lat);
    check("sub_sum", {32'h0, r_sum}, 64'hFFFF_FFFE);
    check("sub_cout", {63'h0, r_cout}, 64'h0);
    check("sub_ovf", {63'h0, r_ovf}, 64'h0);

    run_op(32'h8000_0000, 32'h1, 1'b0, 1'b1, r_sum, r_cout, r_ovf, r_zero, lat);
    check("subovf_sum", {32'h0, r_sum}, 64'h7FFF_FFFF);
    check("subovf_ovf", {63'h0, r_ovf}, 64'h1);
    check("subovf_cout", {63'h0, r_cout}, 64'h1);

    // Reset with operations in flight: nothing may come out afterwards.
    ifa.i_valid = 1'b1; ifa.i_a = 32'hAAAA_0001; ifa.i_b = 32'h3; ifa.i_sub = 1'b0;
    step();
    ifa.i_a = 32'hBBBB_0002;
    step();
    ifa.i_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      check("midrst_no_valid", {63'h0, ifa.o_valid}, 64'h0);
      step();
    end

    // Back-to-back burst of 8 with a 3-cycle output stall.
    for (int i = 0; i < 8; i++) begin
      bp_a[i] = $urandom; bp_b[i] = $urandom;
      bp_c[i] = 1'($urandom_range(1)); bp_s[i] = 1'($urandom_range(1));
    end
    hold_exp = model(32, bp_a[1], bp_b[1], bp_c[1], bp_s[1]);
    sent = 0;
    base_out = n_out_a;
    for (int t = 0; t < 40; t++) begin
      ifa.i_ready = !(t >= 6 && t <= 8);
      ifa.i_valid = (sent < 8);
      if (sent < 8) begin
        ifa.i_a = bp_a[sent]; ifa.i_b = bp_b[sent]; ifa.i_cin = bp_c[sent]; ifa.i_sub = bp_s[sent];
      end
      @(negedge clk);
      if (t >= 6 && t <= 8) begin
        check("bp_stall_ready", {63'h0, ifa.o_ready}, 64'h0);
        check("bp_stall_valid", {63'h0, ifa.o_valid}, 64'h1);
        check("bp_stall_hold", {32'h0, ifa.o_sum}, {32'h0, hold_exp[31:0]});
      end
      if (ifa.i_valid && ifa.o_ready) sent++;
      step();
    end
    ifa.i_valid = 1'b0;
    ifa.i_ready = 1'b1;
    check("bp_sent", 64'(sent), 64'd8);
    check("bp_emitted", 64'(n_out_a - base_out), 64'd8);

    // Random traffic on both instances.
    start_a = n_in_a;
    start_b = n_in_b;
    cyc = 0;
    while ((n_in_a - start_a < 10000 || n_in_b - start_b < 10000) && cyc < 40000) begin
      ifa.i_valid = (n_in_a - start_a < 10000) && ($urandom_range(3) != 0);
      ifa.i_a = $urandom; ifa.i_b = $urandom;
      ifa.i_cin = 1'($urandom_range(1)); ifa.i_sub = 1'($urandom_range(1));
      ifa.i_ready = ($urandom_range(3) != 0);
      ifb.i_valid = (n_in_b - start_b < 10000) && ($urandom_range(3) != 0);
      ifb.i_a = 16'($urandom); ifb.i_b = 16'($urandom);
      ifb.i_cin = 1'($urandom_range(1)); ifb.i_sub = 1'($urandom_range(1));
      ifb.i_ready = ($urandom_range(3) != 0);
      step();
      cyc++;
    end
    ifa.i_valid = 1'b0; ifa.i_ready = 1'b1;
    ifb.i_valid = 1'b0; ifb.i_ready = 1'b1;
    check("rand_accepted_a", 64'(n_in_a - start_a), 64'd10000);
    check("rand_accepted_b", 64'(n_in_b - start_b), 64'd10000);
    for (int n = 0; n < 64 && (exp_q_a.size() != 0 || exp_q_b.size() != 0); n++) step();
    check("drain_a_empty", 64'(exp_q_a.size()), 64'd0);
    check("drain_b_empty", 64'(exp_q_b.size()), 64'd0);
    check("inout_match_a", 64'(n_out_a), 64'(n_in_a - 2));
    check("inout_match_b", 64'(n_out_b), 64'(n_in_b));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
